// File: rtl/fifo_pkg.sv
// Shared defaults and grant encoding for the dual-port-RAM FIFO controller.
package fifo_pkg;

  localparam int unsigned FIFO_DW    = 16;
  localparam int unsigned FIFO_AW    = 3;
  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int unsigned FIFO_CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: write vs read access to the single RAM port pair.
module rr_arb2
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic req_wr_i,
  input  logic req_rd_i,
  output gnt_e gnt_o
);

  logic prio_q, prio_d;

  // prio only advances when both sides contend, giving strict alternation.
  always_comb begin
    gnt_o  = GNT_NONE;
    prio_d = prio_q;
    if (clr_i) begin
      prio_d = 1'b0;
    end else if (req_wr_i && req_rd_i) begin
      gnt_o  = prio_q ? GNT_RD : GNT_WR;
      prio_d = ~prio_q;
    end else if (req_wr_i) begin
      gnt_o = GNT_WR;
    end else if (req_rd_i) begin
      gnt_o = GNT_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an 8x16 dual-port RAM; one RAM operation per cycle, 1-cycle read latency.
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_DW,
  parameter int unsigned AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          ram_we,
  output logic          ram_rd,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(2 ** AW);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          wreq, rreq, wr_gnt, rd_gnt;
  gnt_e          gnt;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wreq  = in_valid && !full;
  assign rreq  = !empty && (!out_valid_q || out_ready);

  // rst also blocks grants so the RAM strobes drop the instant reset asserts.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush || rst),
    .req_wr_i(wreq),
    .req_rd_i(rreq),
    .gnt_o   (gnt)
  );

  assign wr_gnt = (gnt == GNT_WR);
  assign rd_gnt = (gnt == GNT_RD);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_gnt) begin
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end
      // A read refills the output stage in the same cycle it is consumed.
      if (rd_gnt) begin
        rptr_d      = rptr_q + 1'b1;
        count_d     = count_q - 1'b1;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = wr_gnt;
  assign ram_we    = wr_gnt;
  assign ram_rd    = rd_gnt;
  assign ram_waddr = wptr_q;
  assign ram_raddr = rptr_q;
  assign ram_wdata = in_data;
  assign out_data  = ram_rdata;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference model.
module tb_dpram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, ram_we, ram_rd, full, empty;
  logic [15:0] out_data, ram_wdata;
  logic [15:0] ram_rdata;
  logic [2:0]  ram_waddr, ram_raddr;
  logic [3:0]  count;
  logic [15:0] ram_mem [8];

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty)
  );

  // RAM: reset-cleared, registered read, both strobes together are ignored.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_we && !ram_rd) ram_mem[ram_waddr] <= ram_wdata;
      if (ram_rd && !ram_we) ram_rdata <= ram_mem[ram_raddr];
    end
  end

  logic [15:0] dut_vec;
  assign dut_vec = {in_ready, ram_we, ram_rd, full, empty, count, out_valid, ram_waddr, ram_raddr};

  // Reference model: words in RAM as a queue, plus the output register.
  logic [15:0] mq[$];
  logic [15:0] got[$];
  bit          m_ov, m_prio, e_wg, e_rg;
  logic [15:0] m_od;
  int unsigned m_wp, m_rp;

  function automatic void model_reset();
    mq.delete();
    m_ov = 0; m_prio = 0; m_wp = 0; m_rp = 0; m_od = '0;
  endfunction

  function automatic void model_comb();
    bit wreq, rreq;
    wreq = in_valid && (mq.size() < 8);
    rreq = (mq.size() > 0) && (!m_ov || out_ready);
    e_wg = 0; e_rg = 0;
    if (flush || rst) return;
    if (wreq && rreq) begin
      if (m_prio) e_rg = 1; else e_wg = 1;
    end else begin
      e_wg = wreq; e_rg = rreq;
    end
  endfunction

  function automatic void model_seq();
    bit both;
    both = in_valid && (mq.size() < 8) && (mq.size() > 0) && (!m_ov || out_ready);
    if (flush) begin
      model_reset();
      return;
    end
    if (m_ov && out_ready) got.push_back(m_od);
    if (e_wg) begin
      mq.push_back(in_data);
      m_wp = (m_wp + 1) % 8;
    end
    if (e_rg) begin
      m_od = mq.pop_front();
      m_ov = 1;
      m_rp = (m_rp + 1) % 8;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (both) m_prio = !m_prio;
  endfunction

  function automatic logic [15:0] exp_vec();
    int unsigned n;
    n = mq.size();
    return {e_wg, e_wg, e_rg, n == 8, n == 0, 4'(n), m_ov, 3'(m_wp), 3'(m_rp)};
  endfunction

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    model_reset();
    #3;
    chk++;
    if (dut_vec !== 16'b00001_0000_0_000_000) $display("FAIL reset_init dut=%h exp=%h", dut_vec, 16'b00001_0000_0_000_000);
    else pass++;
    #4 rst = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); in_data = 16'($urandom);
      #2; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL reset_traffic cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      tick();
    end
    in_valid = 1; out_ready = 1;
    #2 rst = 1;
    #1;
    chk++;
    if (dut_vec !== 16'b00001_0000_0_000_000) $display("FAIL reset_async dut=%h exp=%h", dut_vec, 16'b00001_0000_0_000_000);
    else pass++;
    model_reset();
    in_valid = 0; out_ready = 0;
    #3 rst = 0;
    tick();
  endtask

  task automatic test_fill();
    int acc;
    acc = 0; out_ready = 0; in_valid = 1;
    for (int i = 0; i < 14; i++) begin
      in_data = 16'(32'h1111 * (acc + 1));
      #2; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL fill_ctl cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      if (m_ov) begin
        chk++;
        if (out_data !== m_od) $display("FAIL fill_data cyc%0d dut=%h exp=%h", i, out_data, m_od);
        else pass++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_data = 16'(32'h1111 * (acc + 1));
    #2;
    chk++;
    if (acc !== 9) $display("FAIL fill_accepted got=%0d exp=9", acc);
    else pass++;
    chk++;
    if ({count, full, in_ready, out_valid, out_data} !== {4'd8, 1'b1, 1'b0, 1'b1, 16'h1111})
      $display("FAIL fill_final count=%0d full=%b in_ready=%b out_valid=%b out_data=%h exp 8 1 0 1 1111",
               count, full, in_ready, out_valid, out_data);
    else pass++;
    tick();
  endtask

  task automatic test_drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL drain_ctl cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      chk++;
      if ({out_valid, out_data} !== {1'b1, 16'(32'h1111 * (i + 1))})
        $display("FAIL drain_seq cyc%0d valid=%b data=%h exp 1 %h", i, out_valid, out_data, 16'(32'h1111 * (i + 1)));
      else pass++;
      tick();
    end
    #1;
    chk++;
    if ({out_valid, empty} !== 2'b01) $display("FAIL drain_end out_valid=%b empty=%b exp 0 1", out_valid, empty);
    else pass++;
  endtask

  task automatic test_contention();
    logic prev_we;
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 10 && mq.size() < 3; i++) begin
      in_data = 16'($urandom);
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL cont_setup cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      tick();
    end
    out_ready = 1; prev_we = 0;
    for (int i = 0; i < 16; i++) begin
      in_data = 16'($urandom);
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL cont_ctl cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      if (m_ov) begin
        chk++;
        if (out_data !== m_od) $display("FAIL cont_data cyc%0d dut=%h exp=%h", i, out_data, m_od);
        else pass++;
      end
      chk++;
      if ((ram_we === ram_rd) || (i > 0 && ram_we === prev_we))
        $display("FAIL cont_alt cyc%0d we=%b rd=%b prev_we=%b", i, ram_we, ram_rd, prev_we);
      else pass++;
      prev_we = ram_we;
      tick();
    end
  endtask

  task automatic test_wrap();
    int pushed;
    logic [2:0] prev_wa, prev_ra;
    bit wrap_w, wrap_r;
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 20 && (mq.size() > 0 || m_ov); i++) tick();
    got.delete();
    pushed = 0; wrap_w = 0; wrap_r = 0;
    prev_wa = ram_waddr; prev_ra = ram_raddr;
    for (int i = 0; i < 400 && got.size() < 20; i++) begin
      in_valid  = (pushed < 20) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 16'(pushed);
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL wrap_ctl cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      if (m_ov) begin
        chk++;
        if (out_data !== m_od) $display("FAIL wrap_data cyc%0d dut=%h exp=%h", i, out_data, m_od);
        else pass++;
      end
      if (prev_wa == 3'd7 && ram_waddr == 3'd0) wrap_w = 1;
      if (prev_ra == 3'd7 && ram_raddr == 3'd0) wrap_r = 1;
      prev_wa = ram_waddr; prev_ra = ram_raddr;
      if (in_valid && in_ready) pushed++;
      tick();
    end
    chk++;
    if (got.size() != 20) $display("FAIL wrap_count got=%0d exp=20", got.size());
    else pass++;
    for (int k = 0; k < got.size(); k++) begin
      chk++;
      if (got[k] !== 16'(k)) $display("FAIL wrap_order idx%0d got=%h exp=%h", k, got[k], 16'(k));
      else pass++;
    end
    chk++;
    if ({wrap_w, wrap_r} !== 2'b11) $display("FAIL wrap_ptr waddr_wrap=%b raddr_wrap=%b exp 1 1", wrap_w, wrap_r);
    else pass++;
  endtask

  task automatic test_flush();
    bit seen;
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 20 && !(mq.size() == 5 && m_ov); i++) begin
      in_data = 16'($urandom);
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL flush_setup cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      tick();
    end
    chk++;
    if ({count, out_valid} !== {4'd5, 1'b1}) $display("FAIL flush_pre count=%0d out_valid=%b exp 5 1", count, out_valid);
    else pass++;
    flush = 1; out_ready = 1;
    #1;
    chk++;
    if ({ram_we, ram_rd, in_ready} !== 3'b000) $display("FAIL flush_strobes we=%b rd=%b in_ready=%b exp 0 0 0", ram_we, ram_rd, in_ready);
    else pass++;
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk++;
    if ({count, out_valid, empty} !== {4'd0, 1'b0, 1'b1}) $display("FAIL flush_after count=%0d out_valid=%b empty=%b exp 0 0 1", count, out_valid, empty);
    else pass++;
    in_valid = 1; in_data = 16'hABCD;
    tick();
    in_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1; model_comb();
      chk++;
      if (dut_vec !== exp_vec()) $display("FAIL flush_pop_ctl cyc%0d dut=%h exp=%h", i, dut_vec, exp_vec());
      else pass++;
      if (out_valid) begin
        seen = 1;
        chk++;
        if (out_data !== 16'hABCD) $display("FAIL flush_pop got=%h exp=abcd", out_data);
        else pass++;
      end
      tick();
    end
    chk++;
    if (!seen) $display("FAIL flush_pop_timeout out_valid never rose");
    else pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_contention();
    test_wrap();
    test_flush();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the team's 8x16 dual-port RAM (reset-cleared storage, registered read data, write/read strobes mutually exclusive) and drives all of its control inputs. It turns a valid/ready push stream and a valid/ready pop stream into RAM write and read strobes. It arbitrates so that the RAM never sees a simultaneous write and read, because the RAM ignores both strobes in that case. It exposes the RAM's registered read data as the FIFO output with a one-stage valid flag.

Parameters:
DW, 16, data width; must match the RAM data width.
AW, 3, address width; DEPTH = 2**AW = 8 entries.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous clear of pointers, count and out_valid
in_valid  in  1  upstream word offered
in_data  in  DW  upstream word
in_ready  out  1  word accepted this cycle when in_valid && in_ready
out_valid  out  1  out_data holds a word
out_data  out  DW  FIFO head word; wired directly from ram_rdata
out_ready  in  1  downstream consumes the word when out_valid && out_ready
ram_we  out  1  to RAM we_in
ram_rd  out  1  to RAM rd_in
ram_waddr  out  AW  to RAM we_addr (write pointer)
ram_raddr  out  AW  to RAM rd_addr (read pointer)
ram_wdata  out  DW  to RAM data_in; equals in_data
ram_rdata  in  DW  from RAM data_out
count  out  AW+1  words held in RAM, not yet read out (0..8)
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async): wptr=0, rptr=0, count=0, out_valid=0, prio=0. Resulting outputs: full=0, empty=1, ram_we=0, ram_rd=0. The RAM shares rst and clears in the same event.
- Write request: wreq = in_valid && !full.
- Read request: rreq = !empty && (!out_valid || out_ready).
- Arbitration (combinational), one RAM operation per cycle:
  - Only wreq → grant write.
  - Only rreq → grant read.
  - Both → prio=0 grants write, prio=1 grants read.
  - prio toggles on every cycle where both were requested, giving strict alternation under contention.
- Invariant: ram_we && ram_rd is never 1 in the same cycle.
- Outputs: ram_we = write granted; ram_rd = read granted; in_ready = write granted. in_ready may depend combinationally on in_valid, out_ready and state.
- Write grant: RAM stores in_data at mem[wptr] at the edge; wptr += 1, wrapping 7→0.
- Read grant in cycle T:
  - RAM registers mem[rptr] at the end of T; rptr += 1, wrapping.
  - out_valid=1 from T+1; out_data = ram_rdata. Read latency is 1 cycle.
- out_valid update: cleared when out_valid && out_ready with no read granted. Stays 1 when a read is granted in the same cycle as consumption, allowing back-to-back pops.
- Output stability: out_data is stable while out_valid && !out_ready, because no read is issued in that state.
- count: +1 on write grant, −1 on read grant, never both in one cycle.
- Capacity: 8 words in RAM plus 1 word held at the output, 9 total.
- Full: wreq=0 and in_ready=0; a read may still proceed.
- Empty: rreq=0; out_valid may still be 1 from an earlier read.
- flush: overrides everything that cycle:
  - No grants; ram_we=ram_rd=0.
  - Next state: pointers=0, count=0, out_valid=0, prio=0.
  - RAM contents are left stale but unreachable.
- Reset mid-operation: async clear as above; any read in flight is discarded and out_valid=0.
- Throughput: 1 word/cycle one-way; 1 push + 1 pop per 2 cycles under sustained contention.

Decomposition:
- Shared package fifo_pkg:
  - DW/AW defaults.
  - Derived DEPTH and count width.
  - A grant encoding enum: GNT_NONE, GNT_WR, GNT_RD.
- Natural sub-module: rr_arb2, a 2-requester round-robin arbiter holding the prio flop and producing the grant vector. Pointers and count stay in the top.
- Integration wrapper instantiates dpram_fifo_ctrl plus the existing RAM; benches target the wrapper.

Test Plan:
1. Reset/idle: assert rst mid-traffic → full=0, empty=1, count=0, out_valid=0, ram_we=ram_rd=0 immediately (asynchronously).
2. Fill with backpressure: out_ready=0, offer 0x1111..0x9999 continuously → exactly 9 words accepted; afterwards count=8, full=1, in_ready=0, out_valid=1, out_data=0x1111.
3. Drain: from the test 2 state, out_ready=1, in_valid=0 → out_data sequence 0x1111..0x9999 on 9 consecutive cycles, then out_valid=0, empty=1.
4. Contention: in_valid=1 and out_ready=1 held 16 cycles with count≥1 → ram_we/ram_rd alternate each cycle, never both 1, order preserved.
5. Wrap: push/pop 20 words 0x0000..0x0013 in random valid/ready patterns → output in order; ram_waddr and ram_raddr observed wrapping 7→0.
6. Flush: with count=5 and out_valid=1, pulse flush one cycle → next cycle count=0, out_valid=0, empty=1, no RAM strobes during the flush cycle; next push 0xABCD pops as 0xABCD.
